alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational 8-bit add/sub ALU between NUM_REQ requesters.
//  Round-robin arbiter with a valid/ready request handshake per requester.
//  Registers the granted operands and drives them to the ALU, then captures
//  the 9-bit result and overflow into a response register.
//  Returns the response with the requester ID on a valid/ready response channel.
//  Sits between requester blocks and the single alu instance.
// PARAMETERS
//  NUM_REQ  4                          number of requesters, >=2
//  ID_W     $clog2(NUM_REQ) (min 1)    width of requester ID (localparam)
// PORTS
//  clk            in   1           single clock, all flops on posedge
//  rst            in   1           synchronous, active-high reset
//  req_valid      in   NUM_REQ     per-requester request valid
//  req_ready      out  NUM_REQ     per-requester accept, one-hot or zero
//  req_a          in   NUM_REQ*8   operand a, requester i in [8*i+7:8*i]
//  req_b          in   NUM_REQ*8   operand b, same packing as req_a
//  req_operand    in   NUM_REQ     0=ADD, 1=SUB, per requester
//  alu_a          out  8           registered operand a to ALU
//  alu_b          out  8           registered operand b to ALU
//  alu_operand    out  1           registered op select to ALU
//  alu_result     in   9 signed    ALU result (combinational from alu_a/b/op)
//  alu_overflow   in   1           ALU overflow flag
//  resp_valid     out  1           response valid
//  resp_ready     in   1           response accept from consumer
//  resp_result    out  9 signed    captured ALU result
//  resp_overflow  out  1           captured ALU overflow
//  resp_id        out  ID_W        index of the requester that issued the op
//  busy           out  1           1 whenever state != IDLE
// BEHAVIOUR
//  FSM states: IDLE, ISSUE, RESP. Exactly one op in flight at a time.
//  IDLE
//   - If any req_valid bit is set, grant g = first set bit searching upward
//     from (last_grant+1) mod NUM_REQ.
//   - req_ready[g] is high combinationally in this cycle.
//   - At the clock edge, latch req_a[g], req_b[g], req_operand[g] and g,
//     set last_grant=g, and go to ISSUE.
//   - If no req_valid bit is set, req_ready is 0 and the FSM stays in IDLE.
//  ISSUE
//   - alu_* hold the latched operands.
//   - At the clock edge, capture alu_result and alu_overflow into
//     resp_result and resp_overflow, set resp_valid=1, and go to RESP.
//  RESP
//   - resp_valid=1; resp_result, resp_overflow and resp_id are held stable.
//   - If resp_ready=1: at the edge, resp_valid=0 and go to IDLE.
//   - Otherwise stay in RESP indefinitely.
//  req_ready is 0 in ISSUE and RESP. No request is accepted while busy.
//  Latency: request accepted in cycle t, resp_valid first high in cycle t+2.
//  Throughput: at most 1 op per 3 cycles.
//  last_grant updates only on an accepted request.
//  A requester dropping req_valid before it is granted is legal.
//  Once accepted, an op is never dropped except by reset.
//  Arithmetic
//   - The block does no arithmetic; the ALU's 9-bit result and overflow are
//     passed through unmodified.
//   - ADD: 9-bit unsigned sum, overflow = bit 8.
//   - SUB: 9-bit two's complement difference, overflow = 0.
//  Reset (any cycle, including mid-operation)
//   - Next state IDLE; any in-flight op is abandoned and produces no response.
//   - Register values: resp_valid, resp_result, resp_overflow, resp_id,
//     alu_a, alu_b, alu_operand all 0; busy=0.
//   - last_grant = NUM_REQ-1, so requester 0 has highest priority first.
//   - req_ready is 0 during the reset cycle.
// TESTING
//  1. Only req0 valid, ADD a=200 b=100 -> req_ready[0] high in cycle t;
//     resp_valid in cycle t+2 with resp_result=9'h12C, resp_overflow=1,
//     resp_id=0.
//  2. Only req2 valid, SUB a=3 b=5 -> resp_result=9'h1FE (-2),
//     resp_overflow=0, resp_id=2.
//  3. All 4 req_valid held high, resp_ready=1 ->
//     grant order 0,1,2,3,0, one grant every 3 cycles.
//  4. resp_ready=0 for 5 cycles while resp_valid ->
//     resp_* stable, req_ready all 0, busy=1; raise resp_ready ->
//     IDLE and a new grant possible in the next cycle.
//  5. rst asserted while in ISSUE -> next cycle resp_valid=0, busy=0,
//     alu_a=0; no response is ever emitted for that op.
//  6. req1 and req3 valid with last_grant=1 -> req3 granted before req1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signal bundle between requesters, alu_arbiter and the shared ALU.
// slave is the arbiter's view; master is the view of the surrounding environment.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ-1:0]   req_operand;

  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic                 alu_operand;
  logic signed [8:0]    alu_result;
  logic                 alu_overflow;

  logic                 resp_valid;
  logic                 resp_ready;
  logic signed [8:0]    resp_result;
  logic                 resp_overflow;
  logic [ID_W-1:0]      resp_id;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, req_operand,
    output req_ready,
    output alu_a, alu_b, alu_operand,
    input  alu_result, alu_overflow,
    output resp_valid, resp_result, resp_overflow, resp_id, busy,
    input  resp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_operand,
    input  req_ready,
    input  alu_a, alu_b, alu_operand,
    output alu_result, alu_overflow,
    input  resp_valid, resp_result, resp_overflow, resp_id, busy,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub ALU between NUM_REQ requesters.
// One op in flight: accept, drive the ALU for one cycle, then hold the response until taken.
//
// state | meaning
// IDLE  | waiting for a request; req_ready asserted for the round-robin winner
// ISSUE | latched operands driven to the ALU, result captured at the next edge
// RESP  | response held on resp_* until resp_ready
module alu_arbiter #(
  parameter int NUM_REQ = 4
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return ID_W'(s);
  endfunction

  // search starts one past the last winner so every requester gets a turn
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && bus.req_valid[rr_index(last_grant, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_index(last_grant, k);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !rst && gnt_found)
      bus.req_ready[gnt_idx] = 1'b1;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      last_grant        <= ID_W'(NUM_REQ - 1);
      bus.alu_a         <= '0;
      bus.alu_b         <= '0;
      bus.alu_operand   <= 1'b0;
      bus.resp_valid    <= 1'b0;
      bus.resp_result   <= '0;
      bus.resp_overflow <= 1'b0;
      bus.resp_id       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            bus.alu_a       <= bus.req_a[8*int'(gnt_idx) +: 8];
            bus.alu_b       <= bus.req_b[8*int'(gnt_idx) +: 8];
            bus.alu_operand <= bus.req_operand[gnt_idx];
            last_grant      <= gnt_idx;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          // last_grant still names the requester of the op in flight
          bus.resp_result   <= bus.alu_result;
          bus.resp_overflow <= bus.alu_overflow;
          bus.resp_id       <= last_grant;
          bus.resp_valid    <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
